vid_pattern_gen: RTL

- vid_io source block: generates 1080p60 video timing (hsync, vsync, VDE) plus a selectable RGB test pattern.
- Drives the pixel-input side of the colour-processing chain in place of the camera pipeline, for bring-up and filter verification.
- Counters, a 3-state run controller and per-frame pattern latching; all outputs registered.

---
 rtl/vid_pattern_gen.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen
// Video timing source (1080p60 by default) with a selectable RGB test pattern.
// Generates hsync/vsync/VDE and pixel data from free-running h/v counters,
// under a three-state run controller (IDLE/RUN/DRAIN). The pattern select
// and solid colour are latched once per frame at pixel (0,0). All outputs
// are registered one clock after the counter decode.
// Optional feature: define VID_PATTERN_GEN_CROSSHAIR_EN to overlay a red
// crosshair on the centre column and centre row of the active area.
// Pixel layout: [23:16]=R, [15:8]=B, [7:0]=G.
module vid_pattern_gen #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 1920,
    parameter int H_FP       = 88,
    parameter int H_SYNC     = 44,
    parameter int H_BP       = 148,
    parameter int V_ACTIVE   = 1080,
    parameter int V_FP       = 4,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 36,
    parameter int SYNC_POL   = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_en,
    input  logic [2:0]            i_pattern,
    input  logic [DATA_WIDTH-1:0] i_solid,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_hsync,
    output logic                  o_vid_vsync,
    output logic                  o_vid_VDE,
    output logic                  o_frame_start,
    output logic                  o_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are at least 8/7 bits wide so the ramp (x[7:0]) and
    // checkerboard (bit 6) taps always exist, even for small timings.
    localparam int HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int VW = ($clog2(V_TOTAL) < 7) ? 7 : $clog2(V_TOTAL);

    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BOX_SIZE = 64;
    localparam int BOX_STEP = 4;
    // Box row is vertically centred: 508 for 1080 active lines.
    localparam int BOX_Y    = (V_ACTIVE - BOX_SIZE) / 2;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] BOX_Y0    = VW'(BOX_Y);
    localparam logic [VW-1:0] BOX_Y1    = VW'(BOX_Y + BOX_SIZE);

    localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_IDLE = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_BLACK = 24'h000000;

`ifdef VID_PATTERN_GEN_CROSSHAIR_EN
    localparam logic [23:0]   C_RED = 24'hFF0000;
    localparam logic [HW-1:0] X_MID = HW'(H_ACTIVE / 2);
    localparam logic [VW-1:0] Y_MID = VW'(V_ACTIVE / 2);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Colour-bar palette, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF; // white
            3'd1:    c = 24'hFF00FF; // yellow
            3'd2:    c = 24'h00FFFF; // cyan
            3'd3:    c = 24'h0000FF; // green
            3'd4:    c = 24'hFFFF00; // magenta
            3'd5:    c = 24'hFF0000; // red
            3'd6:    c = 24'h00FF00; // blue
            default: c = 24'h000000; // black
        endcase
        return c;
    endfunction

    // Control state
    state_t                state_q, state_d;
    logic [HW-1:0]         hcount_q, hcount_d;
    logic [VW-1:0]         vcount_q, vcount_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]         box_x_q, box_x_d;
    logic [2:0]            pat_q, pat_d;
    logic [DATA_WIDTH-1:0] solid_q, solid_d;

    // Output registers
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  vde_q, vde_d;
    logic                  fstart_q, fstart_d;
    logic                  busy_q, busy_d;

    // Decode helpers
    logic                  running_s;
    logic                  h_wrap_s;
    logic                  v_wrap_s;
    logic                  frame_first_s;
    logic                  active_s;
    logic                  hs_s;
    logic                  vs_s;
    logic                  in_box_s;
    logic [2:0]            bar_idx_s;
    logic [2:0]            eff_pat_s;
    logic [DATA_WIDTH-1:0] eff_solid_s;
    logic [DATA_WIDTH-1:0] pix_s;
    logic [DATA_WIDTH-1:0] pix_ovl_s;

    assign running_s     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign h_wrap_s      = (hcount_q == H_LAST);
    assign v_wrap_s      = (vcount_q == V_LAST);
    assign frame_first_s = (hcount_q == '0) && (vcount_q == '0);
    assign active_s      = (hcount_q < H_ACT_END) && (vcount_q < V_ACT_END);
    assign hs_s          = (hcount_q >= HS_START) && (hcount_q < HS_END);
    assign vs_s          = (vcount_q >= VS_START) && (vcount_q < VS_END);
    assign in_box_s      = (hcount_q >= box_x_q)
                        && ({1'b0, hcount_q} < ({1'b0, box_x_q} + (HW+1)'(BOX_SIZE)))
                        && (vcount_q >= BOX_Y0) && (vcount_q < BOX_Y1);

    // Run controller next state, counter advance, box motion and per-frame latch.
    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        frame_cnt_d = frame_cnt_q;
        box_x_d     = box_x_q;
        pat_d       = pat_q;
        solid_d     = solid_q;

        case (state_q)
            ST_IDLE: begin
                hcount_d = '0;
                vcount_d = '0;
                if (i_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (h_wrap_s && v_wrap_s && !i_en) begin
                    state_d = ST_IDLE;
                end else if (i_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                hcount_d = '0;
                vcount_d = '0;
            end
        endcase

        if (running_s) begin
            if (h_wrap_s) begin
                hcount_d = '0;
                if (v_wrap_s) begin
                    vcount_d    = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    // Restart at the left edge once the next step would overrun the line.
                    if (({1'b0, box_x_q} + (HW+1)'(BOX_SIZE + BOX_STEP)) > (HW+1)'(H_ACTIVE)) begin
                        box_x_d = '0;
                    end else begin
                        box_x_d = box_x_q + HW'(BOX_STEP);
                    end
                end else begin
                    vcount_d = vcount_q + VW'(1);
                end
            end else begin
                hcount_d = hcount_q + HW'(1);
            end

            if (frame_first_s) begin
                pat_d   = i_pattern;
                solid_d = i_solid;
            end else begin
                pat_d   = pat_q;
                solid_d = solid_q;
            end
        end else begin
            pat_d   = pat_q;
            solid_d = solid_q;
        end
    end

    // Colour-bar index: number of bar boundaries at or left of hcount.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = bar_idx_s + {2'b00, (int'(hcount_q) >= k * BAR_W)};
        end
    end

    // Pattern generation; at (0,0) the live select is used so a new frame's pattern starts on its first pixel.
    always_comb begin
        eff_pat_s   = frame_first_s ? i_pattern : pat_q;
        eff_solid_s = frame_first_s ? i_solid : solid_q;

        case (eff_pat_s)
            3'd0:    pix_s = DATA_WIDTH'(bar_colour(bar_idx_s));
            3'd1:    pix_s = DATA_WIDTH'({hcount_q[7:0], hcount_q[7:0], hcount_q[7:0]});
            3'd2:    pix_s = DATA_WIDTH'((hcount_q[6] ^ vcount_q[6]) ? C_BLACK : C_WHITE);
            3'd3:    pix_s = DATA_WIDTH'(in_box_s ? C_WHITE : C_BLACK);
            3'd4:    pix_s = eff_solid_s;
            default: pix_s = DATA_WIDTH'(C_BLACK);
        endcase

`ifdef VID_PATTERN_GEN_CROSSHAIR_EN
        if ((hcount_q == X_MID) || (vcount_q == Y_MID)) begin
            pix_ovl_s = DATA_WIDTH'(C_RED);
        end else begin
            pix_ovl_s = pix_s;
        end
`else
        pix_ovl_s = pix_s;
`endif
    end

    // Output next values: decoded timing while running, idle levels otherwise.
    always_comb begin
        data_d   = '0;
        hsync_d  = SYNC_IDLE;
        vsync_d  = SYNC_IDLE;
        vde_d    = 1'b0;
        fstart_d = 1'b0;
        if (running_s) begin
            vde_d    = active_s;
            data_d   = active_s ? pix_ovl_s : '0;
            hsync_d  = hs_s ? SYNC_ACT : SYNC_IDLE;
            vsync_d  = vs_s ? SYNC_ACT : SYNC_IDLE;
            fstart_d = frame_first_s;
        end else begin
            vde_d    = 1'b0;
            data_d   = '0;
            hsync_d  = SYNC_IDLE;
            vsync_d  = SYNC_IDLE;
            fstart_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            hcount_q    <= '0;
            vcount_q    <= '0;
            frame_cnt_q <= 8'd0;
            box_x_q     <= '0;
            pat_q       <= 3'd0;
            solid_q     <= '0;
        end else begin
            state_q     <= state_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            frame_cnt_q <= frame_cnt_d;
            box_x_q     <= box_x_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
        end
    end

    // Output registers; syncs reset to their inactive level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q   <= '0;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
            vde_q    <= 1'b0;
            fstart_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            data_q   <= data_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vde_q    <= vde_d;
            fstart_q <= fstart_d;
            busy_q   <= busy_d;
        end
    end

    assign o_vid_data    = data_q;
    assign o_vid_hsync   = hsync_q;
    assign o_vid_vsync   = vsync_q;
    assign o_vid_VDE     = vde_q;
    assign o_frame_start = fstart_q;
    assign o_busy        = busy_q;

endmodule
